// File: rtl/video_frame_reader_if.sv
// Avalon-MM read port and pixel stream port of the video frame reader.
interface video_frame_reader_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output pix_data, pix_valid, pix_sof, pix_eol,
    input  pix_ready
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  pix_data, pix_valid, pix_sof, pix_eol,
    output pix_ready
  );
endinterface

// File: rtl/video_frame_reader.sv
// Fetches one frame from the framebuffer over Avalon-MM and streams it out as pixels.
// Optional underflow counter built only when VIDEO_READER_UNDERFLOW_CNT_EN is defined.
module video_frame_reader #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_enable,
  input  logic [31:0]           ctrl_base,
  video_frame_reader_if.master  bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           underflow_count
);

  localparam int unsigned PIX_TOTAL = H_RES * V_RES;
  localparam int unsigned IDX_W     = $clog2(PIX_TOTAL + 1);
  localparam int unsigned X_W       = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned Y_W       = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LATCH, RUN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       base_q;
  logic [IDX_W-1:0]  req_idx;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [31:0]       fifo_mem [FIFO_DEPTH];

  logic credit_ok, rd_req, accept, push, pop, fifo_nonempty, last_pix, last_pop;

  // Credits cover both buffered pixels and reads still in flight, so the FIFO never overflows.
  assign credit_ok     = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(outstanding)) < (CNT_W+1)'(FIFO_DEPTH);
  assign rd_req        = (state_q == RUN) && (req_idx < IDX_W'(PIX_TOTAL)) && credit_ok;
  assign accept        = rd_req && !bus.avm_waitrequest;
  assign push          = (state_q == RUN) && bus.avm_readdatavalid;
  assign fifo_nonempty = (fifo_count != '0);
  assign pop           = fifo_nonempty && bus.pix_ready;
  assign last_pix      = (out_x == X_W'(H_RES - 1)) && (out_y == Y_W'(V_RES - 1));
  assign last_pop      = (state_q == RUN) && pop && last_pix;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ctrl_enable) state_d = LATCH;
      LATCH:   state_d = RUN;
      RUN:     if (last_pop) state_d = ctrl_enable ? LATCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request indexing, outstanding credits and raster position.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q      <= '0;
      req_idx     <= '0;
      outstanding <= '0;
      out_x       <= '0;
      out_y       <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= last_pop;
      if (state_q == LATCH) begin
        base_q      <= ctrl_base;
        req_idx     <= '0;
        outstanding <= '0;
        out_x       <= '0;
        out_y       <= '0;
      end else begin
        if (accept) req_idx <= req_idx + IDX_W'(1);
        case ({accept, push})
          2'b10:   outstanding <= outstanding + CNT_W'(1);
          2'b01:   outstanding <= outstanding - CNT_W'(1);
          default: ;
        endcase
        if (pop) begin
          if (out_x == X_W'(H_RES - 1)) begin
            out_x <= '0;
            out_y <= (out_y == Y_W'(V_RES - 1)) ? '0 : out_y + Y_W'(1);
          end else begin
            out_x <= out_x + X_W'(1);
          end
        end
      end
    end
  end

  // Pixel FIFO control; storage below carries no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.avm_readdata;
  end

  assign bus.avm_read    = rd_req;
  assign bus.avm_address = base_q + (32'(req_idx) << 2);
  assign bus.pix_valid   = fifo_nonempty;
  assign bus.pix_data    = fifo_nonempty ? fifo_mem[rd_ptr] : '0;
  assign bus.pix_sof     = fifo_nonempty && (out_x == '0) && (out_y == '0);
  assign bus.pix_eol     = fifo_nonempty && (out_x == X_W'(H_RES - 1));
  assign busy            = (state_q != IDLE);

`ifdef VIDEO_READER_UNDERFLOW_CNT_EN
  logic [15:0] ufl_q;

  // Counts cycles the sink wanted a pixel during a frame but none was buffered.
  always_ff @(posedge clk) begin
    if (reset) begin
      ufl_q <= '0;
    end else if ((state_q == RUN) && bus.pix_ready && !fifo_nonempty && (ufl_q != 16'hFFFF)) begin
      ufl_q <= ufl_q + 16'd1;
    end
  end

  assign underflow_count = ufl_q;
`else
  assign underflow_count = '0;
`endif

endmodule

// File: tb/tb_video_frame_reader.sv
// Directed self-checking bench for video_frame_reader with an Avalon-MM slave model.
module tb_video_frame_reader;
  localparam int unsigned H = 4;
  localparam int unsigned V = 2;
  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_enable;
  logic [31:0] ctrl_base;
  logic        busy;
  logic        frame_done;
  logic [15:0] underflow_count;

  video_frame_reader_if bus ();

  video_frame_reader #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D)) dut (
    .clk             (clk),
    .reset           (reset),
    .ctrl_enable     (ctrl_enable),
    .ctrl_base       (ctrl_base),
    .bus             (bus),
    .busy            (busy),
    .frame_done      (frame_done),
    .underflow_count (underflow_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_lat = 1;
  int stall_left = 0;
  int en_cyc = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int hold_1000 = 0;
  int ufl_model = 0;
  int ufl_from = 0;
  bit ufl_on = 1'b0;

  logic [31:0] rsp_data [$];
  int          rsp_due  [$];
  logic [31:0] acc_addr [$];
  int          acc_cyc  [$];
  logic [31:0] pix_d    [$];
  bit          pix_s    [$];
  bit          pix_e    [$];
  int          pix_c    [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pix_of(input logic [31:0] a);
    return {8'h00, a[23:0] ^ 24'h3C5A96};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave model and observer; runs after the stimulus has settled each cycle.
  initial begin
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdata      = '0;
    bus.avm_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = '0;
      bus.avm_waitrequest   = 1'b0;
      if (reset) begin
        rsp_data.delete();
        rsp_due.delete();
      end else begin
        if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata      = rsp_data[0];
          void'(rsp_data.pop_front());
          void'(rsp_due.pop_front());
        end
        if (bus.avm_read && stall_left > 0) begin
          bus.avm_waitrequest = 1'b1;
          stall_left--;
        end
        if (bus.avm_read && bus.avm_address == 32'h1000) hold_1000++;
        if (bus.avm_read && !bus.avm_waitrequest) begin
          acc_addr.push_back(bus.avm_address);
          acc_cyc.push_back(cyc);
          rsp_due.push_back(cyc + rd_lat);
          rsp_data.push_back(pix_of(bus.avm_address));
        end
        if (frame_done) begin
          fd_cnt++;
          fd_cyc = cyc;
        end
        if (bus.pix_valid && bus.pix_ready) begin
          pix_d.push_back(bus.pix_data);
          pix_s.push_back(bus.pix_sof);
          pix_e.push_back(bus.pix_eol);
          pix_c.push_back(cyc);
        end
        if (ufl_on && fd_cnt == 0 && cyc >= ufl_from && bus.pix_ready && !bus.pix_valid) ufl_model++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rec();
    acc_addr.delete(); acc_cyc.delete();
    pix_d.delete(); pix_s.delete(); pix_e.delete(); pix_c.delete();
    fd_cnt = 0; hold_1000 = 0; ufl_model = 0; ufl_on = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; ctrl_enable = 1'b0; rd_lat = 1; stall_left = 0;
    tick(); tick();
    reset = 1'b0;
    clear_rec();
  endtask

  task automatic start_frame(input logic [31:0] base);
    ctrl_base = base; ctrl_enable = 1'b1; en_cyc = cyc;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (fd_cnt < n && k < budget) begin tick(); k++; end
    check("frame_wait", 32'(fd_cnt), 32'(n));
  endtask

  task automatic wait_pix(input int n, input int budget);
    int k = 0;
    while (int'(pix_d.size()) < n && k < budget) begin tick(); k++; end
    check("pix_wait", 32'(pix_d.size()), 32'(n));
  endtask

  task automatic check_frame(input int first, input logic [31:0] base);
    for (int i = 0; i < int'(H * V); i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      if (first + i < int'(acc_addr.size()))
        check($sformatf("addr%0d", first + i), acc_addr[first + i], a);
      if (first + i < int'(pix_d.size())) begin
        check($sformatf("data%0d", first + i), pix_d[first + i], pix_of(a));
        check($sformatf("sof%0d", first + i), 32'(pix_s[first + i]), 32'(i == 0));
        check($sformatf("eol%0d", first + i), 32'(pix_e[first + i]), 32'((i % int'(H)) == int'(H) - 1));
      end
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_read"}, 32'(bus.avm_read), 32'd0);
    check({pfx, "_addr"}, bus.avm_address, 32'd0);
    check({pfx, "_valid"}, 32'(bus.pix_valid), 32'd0);
    check({pfx, "_data"}, bus.pix_data, 32'd0);
    check({pfx, "_sof"}, 32'(bus.pix_sof), 32'd0);
    check({pfx, "_eol"}, 32'(bus.pix_eol), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(frame_done), 32'd0);
    check({pfx, "_ufl"}, 32'(underflow_count), 32'd0);
  endtask

  initial begin
    int n1000;
    int exp_ufl;
    reset = 1'b1; ctrl_enable = 1'b0; ctrl_base = '0; bus.pix_ready = 1'b0;

    // Reset state, then a plain frame from 0x1000.
    do_reset();
    check_idle_outputs("rst");
    bus.pix_ready = 1'b1;
    start_frame(32'h1000);
    tick();
    ctrl_enable = 1'b0;
    check("latch_busy", 32'(busy), 32'd1);
    wait_frames(1, 200);
    repeat (5) tick();
    check("t1_fd_cnt", 32'(fd_cnt), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_nacc", 32'(acc_addr.size()), 32'd8);
    check("t1_npix", 32'(pix_d.size()), 32'd8);
    if (acc_cyc.size() > 0) check("t1_first_rd", 32'(acc_cyc[0]), 32'(en_cyc + 2));
    if (pix_c.size() == 8) begin
      check("t1_first_pix", 32'(pix_c[0]), 32'(en_cyc + 4));
      check("t1_done_cyc", 32'(fd_cyc), 32'(pix_c[7] + 1));
    end
    check_frame(0, 32'h1000);

    // Slave stalls the first request for three cycles.
    do_reset();
    stall_left = 3;
    start_frame(32'h1000);
    tick();
    ctrl_enable = 1'b0;
    wait_frames(1, 200);
    repeat (3) tick();
    check("t2_hold", 32'(hold_1000), 32'd4);
    n1000 = 0;
    foreach (acc_addr[i]) if (acc_addr[i] == 32'h1000) n1000++;
    check("t2_one_accept", 32'(n1000), 32'd1);
    check("t2_npix", 32'(pix_d.size()), 32'd8);
    check_frame(0, 32'h1000);

    // Sink stalled: fetch stops at the credit limit.
    do_reset();
    bus.pix_ready = 1'b0;
    start_frame(32'h1000);
    tick();
    ctrl_enable = 1'b0;
    repeat (30) tick();
    check("t3_nacc", 32'(acc_addr.size()), 32'd4);
    check("t3_read_off", 32'(bus.avm_read), 32'd0);
    check("t3_valid", 32'(bus.pix_valid), 32'd1);
    check("t3_head", bus.pix_data, pix_of(32'h1000));
    check("t3_sof", 32'(bus.pix_sof), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    bus.pix_ready = 1'b1;
    wait_frames(1, 200);
    repeat (3) tick();
    check("t3_nacc_end", 32'(acc_addr.size()), 32'd8);
    check("t3_npix", 32'(pix_d.size()), 32'd8);
    check_frame(0, 32'h1000);

    // Back-to-back frames; base change takes effect only at the next frame.
    do_reset();
    start_frame(32'h1000);
    wait_pix(3, 200);
    ctrl_base = 32'h2000;
    wait_pix(15, 200);
    ctrl_enable = 1'b0;
    wait_frames(2, 200);
    repeat (5) tick();
    check("t4_fd_cnt", 32'(fd_cnt), 32'd2);
    check("t4_nacc", 32'(acc_addr.size()), 32'd16);
    check("t4_npix", 32'(pix_d.size()), 32'd16);
    check("t4_busy", 32'(busy), 32'd0);
    check_frame(0, 32'h1000);
    check_frame(8, 32'h2000);

    // Reset in the middle of a frame, then a fresh frame.
    do_reset();
    start_frame(32'h1000);
    wait_pix(3, 200);
    reset = 1'b1;
    tick();
    check_idle_outputs("midrst");
    reset = 1'b0;
    clear_rec();
    en_cyc = cyc;
    tick();
    ctrl_enable = 1'b0;
    wait_frames(1, 200);
    repeat (3) tick();
    check("t5_npix", 32'(pix_d.size()), 32'd8);
    if (acc_cyc.size() > 0) check("t5_first_rd", 32'(acc_cyc[0]), 32'(en_cyc + 2));
    check_frame(0, 32'h1000);

    // Slow responses starve the sink at the start of the frame.
    do_reset();
    rd_lat = 5;
    start_frame(32'h1000);
    ufl_from = en_cyc + 2;
    ufl_on = 1'b1;
    tick();
    ctrl_enable = 1'b0;
    for (int k = 0; k < 50 && !bus.pix_valid; k++) tick();
    check("t6_valid", 32'(bus.pix_valid), 32'd1);
`ifdef VIDEO_READER_UNDERFLOW_CNT_EN
    exp_ufl = 6;
`else
    exp_ufl = 0;
`endif
    check("t6_ufl_first", 32'(underflow_count), 32'(exp_ufl));
    wait_frames(1, 300);
    repeat (3) tick();
`ifdef VIDEO_READER_UNDERFLOW_CNT_EN
    exp_ufl = ufl_model;
`else
    exp_ufl = 0;
`endif
    check("t6_ufl_end", 32'(underflow_count), 32'(exp_ufl));
    check("t6_npix", 32'(pix_d.size()), 32'd8);
    check_frame(0, 32'h1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
